// File: rtl/sprite_overlay_pkg.sv
// sprite_overlay_pkg
// shared types, colour table and reset placement for the sprite overlay engine
package sprite_overlay_pkg;

  localparam int COORD_X_W = 10;
  localparam int COORD_Y_W = 9;
  localparam int RESET_Y   = 50;

  typedef enum logic {
    ST_IDLE,
    ST_UPDATE
  } state_t;

  function automatic logic [11:0] sprite_color(input int i);
    logic [3:0] k;
    k = 4'(i);
    case (k)
      4'd0:    return 12'hF00;
      4'd1:    return 12'h0F0;
      4'd2:    return 12'h00F;
      4'd3:    return 12'hFF0;
      4'd4:    return 12'h0FF;
      4'd5:    return 12'hF0F;
      4'd6:    return 12'hF80;
      4'd7:    return 12'h8F0;
      4'd8:    return 12'h08F;
      4'd9:    return 12'hF08;
      4'd10:   return 12'h80F;
      4'd11:   return 12'h0F8;
      4'd12:   return 12'h888;
      4'd13:   return 12'h444;
      4'd14:   return 12'hCCC;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic logic [COORD_X_W-1:0] reset_pos_x(
    input int i,
    input int span
  );
    return COORD_X_W'((50 + 100 * i) % span);
  endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// sprite_hit_test
// combinational check whether one square sprite covers the current pixel
module sprite_hit_test
  import sprite_overlay_pkg::*;
#(
  parameter int SPRITE_SIZE = 50
) (
  input  logic [COORD_X_W-1:0] pos_x,
  input  logic [COORD_Y_W-1:0] pos_y,
  input  logic [COORD_X_W-1:0] x,
  input  logic [COORD_Y_W-1:0] y,
  output logic                 hit
);

  localparam logic [COORD_X_W:0] SZ_X = (COORD_X_W+1)'(SPRITE_SIZE);
  localparam logic [COORD_Y_W:0] SZ_Y = (COORD_Y_W+1)'(SPRITE_SIZE);

  logic [COORD_X_W:0] x_end;
  logic [COORD_Y_W:0] y_end;

  assign x_end = {1'b0, pos_x} + SZ_X;
  assign y_end = {1'b0, pos_y} + SZ_Y;

  assign hit = (x >= pos_x) && ({1'b0, x} < x_end) &&
               (y >= pos_y) && ({1'b0, y} < y_end);

endmodule

// File: rtl/sprite_overlay_engine.sv
// sprite_overlay_engine
// per-frame sprite motion (manual or bouncing) and priority compositing
module sprite_overlay_engine
  import sprite_overlay_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 50,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int STEP        = 1,
  parameter int COLOR_W     = 12,
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 screenEnd,
  input  logic                 active,
  input  logic [COORD_X_W-1:0] x,
  input  logic [COORD_Y_W-1:0] y,
  input  logic [COLOR_W-1:0]   bg_color,
  input  logic                 BTNU,
  input  logic                 BTND,
  input  logic                 BTNL,
  input  logic                 BTNR,
  input  logic                 BTNC,
  input  logic                 auto_mode,
  output logic [COLOR_W-1:0]   pix_color,
  output logic [SEL_W-1:0]     sel_idx,
  output logic                 busy
);

  localparam int X_SPAN = SCREEN_W - SPRITE_SIZE;
  localparam logic [COORD_X_W:0] X_MAX  = (COORD_X_W+1)'(X_SPAN);
  localparam logic [COORD_Y_W:0] Y_MAX  = (COORD_Y_W+1)'(SCREEN_H - SPRITE_SIZE);
  localparam logic [COORD_X_W:0] STEP_X = (COORD_X_W+1)'(STEP);
  localparam logic [COORD_Y_W:0] STEP_Y = (COORD_Y_W+1)'(STEP);
  localparam logic [SEL_W-1:0]   LAST   = SEL_W'(NUM_SPRITES - 1);

  logic [5:0] raw, s1, s2;
  logic       btnc_q, se_q, frame_tick, btnc_edge, sel_pend;
  // cmd = {mode, up, down, left, right}
  logic [4:0] cmd;
  logic [SEL_W-1:0] idx;
  state_t state, state_n;

  logic [COORD_X_W-1:0] pos_x [NUM_SPRITES];
  logic [COORD_Y_W-1:0] pos_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dx_neg, dy_neg, hit;

  logic [COORD_X_W:0] cx, nx;
  logic [COORD_Y_W:0] cy, ny;
  logic               ndx, ndy;
  logic [COLOR_W-1:0] win_color;

  assign raw = {auto_mode, BTNC, BTNU, BTND, BTNL, BTNR};
  assign btnc_edge = s2[4] & ~btnc_q;
  assign busy = (state == ST_UPDATE);

  // synchronisers and edge history for select and frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      btnc_q <= 1'b0;
      se_q <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      btnc_q <= s2[4];
      se_q <= screenEnd;
      frame_tick <= screenEnd & ~se_q;
    end
  end

  // update fsm state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else state <= state_n;
  end

  // walk all sprites once per frame tick
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (frame_tick) state_n = ST_UPDATE;
      ST_UPDATE: if (idx == LAST) state_n = ST_IDLE;
    endcase
  end

  // next position and direction of the sprite being walked
  always_comb begin
    cx  = {1'b0, pos_x[idx]};
    cy  = {1'b0, pos_y[idx]};
    nx  = cx;
    ny  = cy;
    ndx = dx_neg[idx];
    ndy = dy_neg[idx];
    if (cmd[4]) begin
      if (dx_neg[idx]) begin
        if (cx <= STEP_X) begin
          nx = '0;
          ndx = 1'b0;
        end else nx = cx - STEP_X;
      end else if (cx + STEP_X >= X_MAX) begin
        nx = X_MAX;
        ndx = 1'b1;
      end else nx = cx + STEP_X;
      if (dy_neg[idx]) begin
        if (cy <= STEP_Y) begin
          ny = '0;
          ndy = 1'b0;
        end else ny = cy - STEP_Y;
      end else if (cy + STEP_Y >= Y_MAX) begin
        ny = Y_MAX;
        ndy = 1'b1;
      end else ny = cy + STEP_Y;
    end else if (idx == sel_idx) begin
      if (cmd[0] & ~cmd[1])
        nx = (cx + STEP_X > X_MAX) ? X_MAX : cx + STEP_X;
      else if (cmd[1] & ~cmd[0])
        nx = (cx < STEP_X) ? '0 : cx - STEP_X;
      if (cmd[3] & ~cmd[2])
        ny = (cy < STEP_Y) ? '0 : cy - STEP_Y;
      else if (cmd[2] & ~cmd[3])
        ny = (cy + STEP_Y > Y_MAX) ? Y_MAX : cy + STEP_Y;
    end
  end

  // latch controls at frame start, write one sprite per update cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      cmd <= '0;
      dx_neg <= '0;
      dy_neg <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x[i] <= reset_pos_x(i, X_SPAN);
        pos_y[i] <= COORD_Y_W'(RESET_Y);
      end
    end else if (state == ST_IDLE) begin
      if (frame_tick) begin
        idx <= '0;
        cmd <= {s2[5], s2[3:0]};
      end
    end else begin
      pos_x[idx] <= nx[COORD_X_W-1:0];
      pos_y[idx] <= ny[COORD_Y_W-1:0];
      dx_neg[idx] <= ndx;
      dy_neg[idx] <= ndy;
      idx <= idx + 1'b1;
    end
  end

  // select cycling, deferred while the sprites are being walked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_idx <= '0;
      sel_pend <= 1'b0;
    end else if (state == ST_UPDATE) begin
      if (btnc_edge) sel_pend <= 1'b1;
    end else begin
      if (sel_pend | btnc_edge)
        sel_idx <= (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
      sel_pend <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_test #(
      .SPRITE_SIZE(SPRITE_SIZE)
    ) u_hit (
      .pos_x(pos_x[g]),
      .pos_y(pos_y[g]),
      .x    (x),
      .y    (y),
      .hit  (hit[g])
    );
  end

  // lowest covering index wins over the background
  always_comb begin
    win_color = bg_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (hit[i]) win_color = COLOR_W'(sprite_color(i));
  end

  // registered pixel output, blanked outside the visible region
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_color <= '0;
    else pix_color <= active ? win_color : '0;
  end

endmodule

// File: tb/tb_sprite_overlay_engine.sv
// tb_sprite_overlay_engine
// directed checks of motion, select, compositing and reset
module tb_sprite_overlay_engine;

  logic        clk = 1'b0;
  logic        reset, screenEnd, active;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] bg_color;
  logic        BTNU, BTND, BTNL, BTNR, BTNC, auto_mode;
  logic [11:0] pix_color;
  logic [1:0]  sel_idx;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [11:0] BG = 12'h123;
  localparam logic [11:0] C0 = 12'hF00;
  localparam logic [11:0] C1 = 12'h0F0;
  localparam logic [11:0] C2 = 12'h00F;
  localparam logic [11:0] C3 = 12'hFF0;

  sprite_overlay_engine dut (
    .clk      (clk),
    .reset    (reset),
    .screenEnd(screenEnd),
    .active   (active),
    .x        (x),
    .y        (y),
    .bg_color (bg_color),
    .BTNU     (BTNU),
    .BTND     (BTND),
    .BTNL     (BTNL),
    .BTNR     (BTNR),
    .BTNC     (BTNC),
    .auto_mode(auto_mode),
    .pix_color(pix_color),
    .sel_idx  (sel_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic probe(input int px, input int py,
                       input logic [11:0] exp, input string tag);
    @(negedge clk);
    x = 10'(px);
    y = 9'(py);
    active = 1'b1;
    @(negedge clk);
    check(tag, 32'(pix_color), 32'(exp));
    active = 1'b0;
  endtask

  task automatic frame(output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    screenEnd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) screenEnd = 1'b0;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic frames(input int n);
    int bc;
    for (int i = 0; i < n; i++) frame(bc);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic press_c();
    @(negedge clk);
    BTNC = 1'b1;
    settle();
    BTNC = 1'b0;
    settle();
  endtask

  initial begin
    int bc;
    int n;
    reset = 1'b1;
    screenEnd = 1'b0;
    active = 1'b0;
    x = '0;
    y = '0;
    bg_color = BG;
    {BTNU, BTND, BTNL, BTNR, BTNC, auto_mode} = '0;
    repeat (3) @(negedge clk);
    check("rst_pix", 32'(pix_color), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel", 32'(sel_idx), 0);
    reset = 1'b0;

    probe(50, 50, C0, "rst_s0");
    probe(49, 50, BG, "rst_s0_left");
    probe(150, 99, C1, "rst_s1");
    probe(150, 100, BG, "rst_s1_below");
    probe(399, 50, C3, "rst_s3");
    probe(0, 0, BG, "bg_origin");
    @(negedge clk);
    x = 10'd60;
    y = 9'd60;
    active = 1'b0;
    @(negedge clk);
    check("inactive", 32'(pix_color), 0);

    BTNR = 1'b1;
    settle();
    frame(bc);
    check("busy_len", 32'(bc), 4);
    BTNR = 1'b0;
    settle();
    probe(50, 50, BG, "r_s0_vacated");
    probe(100, 50, C0, "r_s0_moved");
    probe(150, 50, C1, "r_s1_hold");
    probe(149, 50, BG, "r_s1_left");
    probe(250, 50, C2, "r_s2_hold");
    probe(350, 50, C3, "r_s3_hold");
    probe(400, 50, BG, "r_s3_right");

    @(negedge clk);
    screenEnd = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sel_busy_seen", 32'(busy), 1);
    screenEnd = 1'b0;
    BTNC = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sel_busy_done", 32'(busy), 0);
    check("sel_deferred", 32'(sel_idx), 0);
    @(negedge clk);
    check("sel_applied", 32'(sel_idx), 1);
    BTNC = 1'b0;
    settle();

    BTNL = 1'b1;
    settle();
    frames(60);
    BTNL = 1'b0;
    settle();
    probe(95, 60, C0, "overlap_prio");
    probe(101, 60, C1, "s1_after_left");
    probe(139, 60, C1, "s1_right_edge");
    probe(140, 60, BG, "s1_past_edge");

    press_c();
    press_c();
    check("sel_three", 32'(sel_idx), 3);
    press_c();
    check("sel_wrap", 32'(sel_idx), 0);

    BTNL = 1'b1;
    settle();
    frames(60);
    BTNL = 1'b0;
    settle();
    probe(0, 50, C0, "clamp_x0");
    probe(49, 99, C0, "clamp_corner");
    probe(50, 50, BG, "clamp_right");

    BTNU = 1'b1;
    BTND = 1'b1;
    settle();
    frames(1);
    BTNU = 1'b0;
    BTND = 1'b0;
    settle();
    probe(0, 49, BG, "ud_cancel_top");
    probe(0, 99, C0, "ud_cancel_bot");

    BTNU = 1'b1;
    settle();
    frames(1);
    BTNU = 1'b0;
    settle();
    probe(0, 49, C0, "up_top");
    probe(0, 98, C0, "up_bot_in");
    probe(0, 99, BG, "up_bot_out");

    auto_mode = 1'b1;
    settle();
    frames(239);
    probe(589, 289, C3, "auto_589");
    probe(588, 289, BG, "auto_589_left");
    frames(1);
    probe(589, 290, BG, "auto_590_left");
    probe(639, 290, C3, "auto_590_right");
    frames(1);
    probe(589, 291, C3, "bounce_back");
    probe(639, 291, BG, "bounce_right");

    @(negedge clk);
    screenEnd = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1'b1;
    screenEnd = 1'b0;
    auto_mode = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pix", 32'(pix_color), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("mid_rst_sel", 32'(sel_idx), 0);
    probe(50, 50, C0, "mid_rst_s0");
    probe(49, 50, BG, "mid_rst_s0_left");
    probe(150, 50, C1, "mid_rst_s1");
    probe(250, 50, C2, "mid_rst_s2");
    probe(350, 99, C3, "mid_rst_s3");
    probe(400, 50, BG, "mid_rst_s3_right");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_overlay_engine.md
# sprite_overlay_engine

Parametrised multi-sprite overlay stage sitting between the VGA timing generator/palette path and the `VGA_R/G/B` pins. It holds `NUM_SPRITES` square sprites with independent positions and directions, moves them once per frame (manual button steering of one selected sprite, or autonomous edge-bouncing for all sprites), and composites them over the background colour with fixed priority. Updates run in a clocked FSM triggered by the frame-end pulse, so no logic is clocked by a derived signal.

## Interface
- `NUM_SPRITES`, 4: sprite count, 1..16.
- `SPRITE_SIZE`, 50: sprite side length in pixels.
- `SCREEN_W`, 640: visible width.
- `SCREEN_H`, 480: visible height.
- `STEP`, 1: pixels moved per frame per axis.
- `COLOR_W`, 12: colour width, 4:4:4 RGB.

- `clk`  in  1  100 MHz system clock; sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `screenEnd`  in  1  frame-end pulse from the timing generator, clk-synchronous, may last several clk cycles.
- `active`  in  1  visible-region flag.
- `x`  in  10  current pixel column.
- `y`  in  9  current pixel row.
- `bg_color`  in  COLOR_W  background colour from the palette RAM.
- `BTNU`, `BTND`, `BTNL`, `BTNR`  in  1 each  raw direction buttons.
- `BTNC`  in  1  raw select button; cycles the selected sprite.
- `auto_mode`  in  1  0 = manual steering, 1 = autonomous bounce.
- `pix_color`  out  COLOR_W  composited pixel colour.
- `sel_idx`  out  $clog2(NUM_SPRITES) (min 1)  index of the selected sprite.
- `busy`  out  1  high while the update FSM is walking the sprites.

## Operation
- Buttons and `auto_mode`: 2-flop synchronisers. `BTNC` is also rising-edge detected.
- `screenEnd`: rising-edge detected to give a one-cycle `frame_tick`. Further levels of the same pulse are ignored.
- FSM states: IDLE and UPDATE.
  - IDLE → UPDATE on `frame_tick`. At this transition, latch the synchronised buttons and mode, and set the index counter to 0.
  - UPDATE processes sprite `i` in one cycle and increments `i`. After sprite `NUM_SPRITES-1` it returns to IDLE.
  - `busy` = (state == UPDATE).
  - A `frame_tick` during UPDATE is dropped.
- Manual mode:
  - Only sprite `sel_idx` moves.
  - Up/down each move by STEP; if both are pressed they cancel. Left/right behave the same way.
  - Results are clamped to x in [0, SCREEN_W-SPRITE_SIZE] and y in [0, SCREEN_H-SPRITE_SIZE].
  - All other sprites hold their position.
- Autonomous mode:
  - Every sprite moves STEP along its direction bits `dx_neg`/`dy_neg`.
  - If the next position would pass a bound, it is clamped to that bound and the axis direction bit toggles (reflection).
  - Buttons are ignored.
- Direction bits are only modified in autonomous mode and persist across mode changes.
- Arithmetic: positions are computed one bit wider than the coordinate, then compared and clamped. There is no wrap-around under any input.
- Select:
  - A `BTNC` edge increments `sel_idx`, wrapping from NUM_SPRITES-1 to 0.
  - An edge arriving during UPDATE is held in a pending flag and applied on the first IDLE cycle.
  - A second edge while one is already pending is dropped.
- Compositing:
  - Sprite `i` covers the pixel when pos_x ≤ x < pos_x+SPRITE_SIZE and pos_y ≤ y < pos_y+SPRITE_SIZE.
  - The lowest covering index wins and supplies its colour from the package table.
  - If no sprite covers the pixel, `bg_color` is used.
  - If `active` = 0, the output is 0.
- Reset values:
  - pos_x[i] = 50+100·i (mod SCREEN_W-SPRITE_SIZE), pos_y[i] = 50, direction bits 0.
  - `sel_idx` 0, `pix_color` 0, `busy` 0, FSM in IDLE, pending flag 0.
- A reset asserted mid-UPDATE aborts the update immediately. Sprites already written revert to their reset values.

## Timing
- `pix_color` is registered: 1 clk latency from `x`, `y`, `active`, `bg_color`.
- Button to latch: 2 clk synchroniser delay, then sampled at the next `frame_tick`.
- `frame_tick` is asserted 1 clk after the `screenEnd` rise.
- UPDATE lasts exactly NUM_SPRITES cycles.
- Positions change only during UPDATE, which falls inside blanking, so there is no mid-frame tearing.
- A position written in cycle `i` of UPDATE is visible on `pix_color` 1 clk later.

## Structure
- Package `sprite_overlay_pkg`:
  - sprite colour table (12-bit constants, at least 16 entries);
  - reset position function;
  - FSM state enum;
  - `COORD_X_W`=10 and `COORD_Y_W`=9.
- Sub-module `sprite_hit_test`: combinational per-sprite bounds compare. Instantiated NUM_SPRITES times and feeding a priority encoder.

## Test plan
- Reset then one frame, manual, BTNR held, sel 0 → sprite 0 x 50→51; `busy` high for exactly 4 clk; sprites 1–3 unchanged.
- Manual, sprite 0 at x=0, BTNL held for 3 frames → x stays 0. BTNU+BTND together → y unchanged.
- Autonomous, sprite at x=589 (bound 590), dx_neg=0 → next frames x=590 with dx_neg=1, then 589.
- `BTNC` edge during UPDATE → `sel_idx` changes on the first IDLE cycle. From `sel_idx`=3 (N=4), one edge → 0.
- Sprites 0 and 1 overlapping at pixel (120,60) → `pix_color` = colour[0] one clk later. Pixel (0,0) with `active`=1 → `bg_color`. `active`=0 → 0.
- Reset asserted on cycle 2 of UPDATE → all positions at reset values, `busy`=0, `pix_color`=0.
